// File: rtl/i2c_slave.sv
// I2C target answering one 7-bit address; never drives SCL, no clock stretching.
// Written bytes strobe out on rx_valid; read bytes are fetched with a one-cycle tx_req.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h34
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       scl,
  inout  wire        sda,
  input  logic       msb_lsb,
  input  logic [7:0] tx_byte,
  output logic       tx_req,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       order_q, order_d;
  logic       rw_q, rw_d;
  logic       ph_q, ph_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       rx_valid_q, rx_valid_d;

  logic scl_s1_q, scl_s2_q, scl_d1_q;
  logic sda_s1_q, sda_s2_q, sda_d1_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in, shift_adv, tx_rest;
  logic       shift_bit, tx_first;

  assign sda      = oe_q ? 1'b0 : 1'bz;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

  // START/STOP need SCL high in both samples, so a simultaneous SCL/SDA change is data
  assign scl_rise  = scl_s2_q & ~scl_d1_q;
  assign scl_fall  = ~scl_s2_q & scl_d1_q;
  assign start_det = scl_s2_q & scl_d1_q & sda_d1_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_d1_q & ~sda_d1_q & sda_s2_q;

  assign shift_in  = order_q ? {shift_q[6:0], sda_s2_q} : {sda_s2_q, shift_q[7:1]};
  assign shift_bit = order_q ? shift_q[7] : shift_q[0];
  assign shift_adv = order_q ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
  assign tx_first  = order_q ? tx_byte[7] : tx_byte[0];
  assign tx_rest   = order_q ? {tx_byte[6:0], 1'b0} : {1'b0, tx_byte[7:1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_byte_d  = rx_byte_q;
    order_d    = order_q;
    rw_d       = rw_q;
    ph_d       = ph_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_req     = 1'b0;
    if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = 3'd0;
      order_d = msb_lsb;
      oe_d    = 1'b0;
      ph_d    = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (shift_in[7:1] == SLAVE_ADDR) begin
              state_d = S_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = shift_in[0];
              ph_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
          if (!ph_q) begin
            ph_d = 1'b1;
            oe_d = 1'b1;
            if (state_q == S_ADDR_ACK && rw_q) begin
              tx_req  = 1'b1;
              shift_d = tx_byte;
            end
          end else begin
            ph_d = 1'b0;
            if (state_q == S_ADDR_ACK && rw_q) begin
              oe_d    = ~shift_bit;
              shift_d = shift_adv;
              cnt_d   = 3'd1;
              state_d = S_TX;
            end else begin
              oe_d    = 1'b0;
              cnt_d   = 3'd0;
              state_d = S_RX;
            end
          end
        end
        S_RX: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_byte_d  = shift_in;
            rx_valid_d = 1'b1;
            ph_d       = 1'b0;
            state_d    = S_RX_ACK;
          end
        end
        // cnt counts bits already presented; wrap to 0 means all 8 are out
        S_TX: if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            oe_d    = 1'b0;
            state_d = S_TX_ACK;
          end else begin
            oe_d    = ~shift_bit;
            shift_d = shift_adv;
            cnt_d   = cnt_q + 3'd1;
          end
        end
        S_TX_ACK: begin
          if (scl_rise && sda_s2_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            tx_req  = 1'b1;
            oe_d    = ~tx_first;
            shift_d = tx_rest;
            cnt_d   = 3'd1;
            state_d = S_TX;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_d1_q   <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_d1_q   <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      rx_byte_q  <= 8'h00;
      order_q    <= 1'b1;
      rw_q       <= 1'b0;
      ph_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      scl_s1_q   <= scl;
      scl_s2_q   <= scl_s1_q;
      scl_d1_q   <= scl_s2_q;
      sda_s1_q   <= sda;
      sda_s2_q   <= sda_s1_q;
      sda_d1_q   <= sda_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_byte_q  <= rx_byte_d;
      order_q    <= order_d;
      rw_q       <= rw_d;
      ph_q       <= ph_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged master, local-logic byte source, and a
// scoreboard monitor comparing rx_valid bytes and tx_req counts against a transaction model.
`timescale 1ns/1ps
module tb_i2c_slave;
  localparam logic [6:0] ADDR = 7'h34;
  localparam int Q = 80;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       msb_lsb = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_req, rx_valid, busy;
  logic [7:0] rx_byte;
  wire        sda_w;

  assign sda_w = m_low ? 1'b0 : 1'bz;
  pullup pu (sda_w);

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
    .clk(clk), .arstn(arstn), .scl(scl), .sda(sda_w), .msb_lsb(msb_lsb),
    .tx_byte(tx_byte), .tx_req(tx_req), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .busy(busy)
  );

  int         n_tests = 0;
  int         n_fail = 0;
  int         txreq_seen = 0;
  int         txreq_exp = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_plan[$];
  logic [7:0] xd[3];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Local-logic model serves tx_plan in order and scores every rx_valid strobe
  task automatic monitor();
    logic       pend;
    logic [7:0] e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: rx_valid with byte %02h, none expected (t=%0t)", rx_byte, $time);
        end else begin
          e = exp_rx.pop_front();
          check("rx_byte", rx_byte, e);
        end
      end
      if (tx_req) begin
        txreq_seen++;
        pend = 1'b1;
      end
      @(posedge clk);
      #1;
      if (pend && tx_plan.size() != 0) void'(tx_plan.pop_front());
      pend = 1'b0;
      tx_byte = (tx_plan.size() != 0) ? tx_plan[0] : 8'h00;
    end
  endtask

  task automatic bit_w(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic bit_r(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_w; #Q; scl = 1'b0; #Q;
  endtask

  task automatic start_c();
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic stop_c();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic msb, output logic ack);
    logic b;
    for (int i = 0; i < 8; i++) bit_w(msb ? v[7-i] : v[i]);
    bit_r(b);
    ack = ~b;
  endtask

  task automatic recv_byte(input logic msb, input logic give_ack, output logic [7:0] v);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_r(b);
      if (msb) v[7-i] = b; else v[i] = b;
    end
    bit_w(~give_ack);
  endtask

  // One transaction: data in xd[0..n-1]; reads ACK all but the last byte
  task automatic do_xfer(input logic [6:0] addr, input logic rw, input logic msb,
                         input int n, input logic do_stop);
    logic       ack, match;
    logic [7:0] got;
    match = (addr == ADDR);
    if (rw && match) begin
      for (int k = 0; k < n; k++) tx_plan.push_back(xd[k]);
      txreq_exp += n;
    end
    msb_lsb = msb;
    start_c();
    send_byte({addr, rw}, msb, ack);
    check("addr_ack", ack, match);
    check("busy_addr", busy, match);
    if (!rw) begin
      for (int k = 0; k < n; k++) begin
        if (match) exp_rx.push_back(xd[k]);
        send_byte(xd[k], msb, ack);
        check("data_ack", ack, match);
      end
    end else if (match) begin
      for (int k = 0; k < n; k++) begin
        recv_byte(msb, k != n - 1, got);
        check("rd_byte", got, xd[k]);
      end
      check("busy_nack", busy, 1'b0);
    end else begin
      recv_byte(msb, 1'b0, got);
      check("rd_idle_bus", got, 8'hFF);
    end
    check("tx_req_count", txreq_seen, txreq_exp);
    check("rx_pending", exp_rx.size(), 0);
    if (do_stop) begin
      stop_c();
      check("busy_stop", busy, 1'b0);
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] a;
    logic [6:0] ra;
    fork
      monitor();
    join_none

    #50;
    check("rst_sda", sda_w, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_rx_byte", rx_byte, 8'h00);
    arstn = 1'b1;
    #(4*Q);

    xd[0] = 8'h34;
    do_xfer(ADDR, 1'b0, 1'b1, 1, 1'b1);
    check("rx_byte_34", rx_byte, 8'h34);

    xd[0] = 8'h29;
    do_xfer(ADDR, 1'b1, 1'b1, 1, 1'b1);

    xd[0] = 8'h5A;
    do_xfer(7'h35, 1'b0, 1'b1, 1, 1'b1);
    check("rx_byte_held", rx_byte, 8'h34);

    xd[0] = 8'hA1;
    do_xfer(ADDR, 1'b0, 1'b0, 1, 1'b1);
    check("rx_byte_a1", rx_byte, 8'hA1);
    xd[0] = 8'h5C;
    do_xfer(ADDR, 1'b1, 1'b0, 1, 1'b1);

    xd[0] = 8'h11; xd[1] = 8'h22;
    do_xfer(ADDR, 1'b0, 1'b1, 2, 1'b0);
    check("rx_byte_22", rx_byte, 8'h22);
    xd[0] = 8'h96; xd[1] = 8'h3F;
    do_xfer(ADDR, 1'b1, 1'b1, 2, 1'b1);

    // Reset while the slave is holding the address ACK low
    msb_lsb = 1'b1;
    start_c();
    a = {ADDR, 1'b0};
    for (int i = 0; i < 8; i++) bit_w(a[7-i]);
    m_low = 1'b0;
    #Q;
    check("ack_driven", sda_w, 1'b0);
    arstn = 1'b0;
    #1;
    check("sda_async_release", sda_w, 1'b1);
    check("busy_async_rst", busy, 1'b0);
    #(Q);
    arstn = 1'b1;
    stop_c();

    // Reset during bit 4 of a data byte
    start_c();
    send_byte({ADDR, 1'b0}, 1'b1, ack);
    check("addr_ack_pre_rst", ack, 1'b1);
    for (int i = 0; i < 3; i++) bit_w(1'b1);
    m_low = 1'b0; #Q; scl = 1'b1; #Q;
    arstn = 1'b0;
    #1;
    check("rst4_sda", sda_w, 1'b1);
    check("rst4_busy", busy, 1'b0);
    check("rst4_rx_byte", rx_byte, 8'h00);
    check("rst4_rx_valid", rx_valid, 1'b0);
    #Q; scl = 1'b0; #Q;
    arstn = 1'b1;
    stop_c();
    xd[0] = 8'hC3;
    do_xfer(ADDR, 1'b0, 1'b1, 1, 1'b1);
    check("rx_byte_after_rst", rx_byte, 8'hC3);

    // STOP in the middle of a data byte
    start_c();
    send_byte({ADDR, 1'b0}, 1'b1, ack);
    check("addr_ack_pre_stop", ack, 1'b1);
    bit_w(1'b0); bit_w(1'b1); bit_w(1'b0);
    stop_c();
    #(2*Q);
    check("busy_mid_stop", busy, 1'b0);
    check("rx_byte_mid_stop", rx_byte, 8'hC3);

    for (int t = 0; t < 14; t++) begin
      ra = ($urandom_range(0, 2) == 0) ? 7'($urandom) : ADDR;
      for (int k = 0; k < 3; k++) xd[k] = 8'($urandom);
      do_xfer(ra, 1'($urandom), 1'($urandom), $urandom_range(1, 2),
              (t == 13) ? 1'b1 : 1'($urandom));
    end

    #(4*Q);
    check("final_rx_queue", exp_rx.size(), 0);
    check("final_tx_plan", tx_plan.size(), 0);
    check("final_tx_req", txreq_seen, txreq_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
